// File: rtl/pixel_stream_capture.sv
// Captures one complete visible frame from the renderer pixel stream into an RGB444 valid/ready
// stream with SOF/EOL markers. Define CAPTURE_CRC_EN to build the CRC-16/CCITT over accepted pixels.
module pixel_stream_capture #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  sx_in,
  input  logic [9:0]  sy_in,
  input  logic        de_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        arm_in,
  output logic [11:0] m_data_out,
  output logic        m_sof_out,
  output logic        m_eol_out,
  output logic        m_valid_out,
  input  logic        m_ready_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        overflow_out,
  output logic        seq_err_out,
  output logic [18:0] pix_count_out,
  output logic [15:0] crc_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] XLast = 10'(H_RES - 1);
  localparam logic [9:0] YLast = 10'(V_RES - 1);
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_e;
  state_e state_q, state_d;

  logic [9:0]      ex_q, ey_q, ex_d, ey_d;
  logic            overflow_q, seq_err_q;
  logic [18:0]     pix_count_q;
  logic [13:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;

  logic        start_pix, pix_valid, pix_last, pix_eol, seq_bad, arm_go;
  logic        push, pop, fifo_empty;
  logic [11:0] pix_data;
  logic        unused_low_bits;

  assign unused_low_bits = ^{r_in[3:0], g_in[3:0], b_in[3:0]};

  assign start_pix  = (state_q == StArmed) && de_in && (sx_in == '0) && (sy_in == '0);
  assign pix_valid  = start_pix || ((state_q == StCapture) && de_in);
  assign pix_eol    = (sx_in == XLast);
  assign pix_last   = pix_eol && (sy_in == YLast);
  assign pix_data   = {r_in[7:4], g_in[7:4], b_in[7:4]};
  assign seq_bad    = (state_q == StCapture) && de_in && ((sx_in != ex_q) || (sy_in != ey_q));
  assign arm_go     = (state_q == StIdle) && arm_in;
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && m_ready_in;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push       = pix_valid && ((count_q != FifoFull) || pop);

  // Expected position always follows the observed pixel, which also re-syncs after an error
  always_comb begin
    ex_d = ex_q;
    ey_d = ey_q;
    if (pix_valid) begin
      if (pix_eol) begin
        ex_d = '0;
        ey_d = sy_in + 10'd1;
      end else begin
        ex_d = sx_in + 10'd1;
        ey_d = sy_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arm_in) state_d = StArmed;
      StArmed:   if (start_pix) state_d = pix_last ? StDrain : StCapture;
      StCapture: if (de_in && pix_last) state_d = StDrain;
      StDrain:   if (fifo_empty) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_out = (state_q != StIdle);
    done_out = (state_q == StDrain) && fifo_empty;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ex_q        <= '0;
      ey_q        <= '0;
      overflow_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      pix_count_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      ex_q <= ex_d;
      ey_q <= ey_d;
      if (arm_go) begin
        overflow_q  <= 1'b0;
        seq_err_q   <= 1'b0;
        pix_count_q <= '0;
      end else begin
        if (pix_valid && !push) overflow_q <= 1'b1;
        if (seq_bad) seq_err_q <= 1'b1;
        if (push && (pix_count_q != '1)) pix_count_q <= pix_count_q + 19'd1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {start_pix, pix_eol, pix_data};
  end

  assign m_valid_out = !fifo_empty;
  assign {m_sof_out, m_eol_out, m_data_out} = m_valid_out ? mem_q[rd_ptr_q] : 14'd0;
  assign overflow_out  = overflow_q;
  assign seq_err_out   = seq_err_q;
  assign pix_count_out = pix_count_q;

`ifdef CAPTURE_CRC_EN
  logic [15:0] crc_q;

  // CRC-16/CCITT, MSB first, one 16-bit word per call
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in)      crc_q <= '0;
    else if (arm_go) crc_q <= 16'hFFFF;
    else if (push)   crc_q <= crc16_step(crc_q, {4'h0, pix_data});
  end

  assign crc_out = crc_q;
`else
  assign crc_out = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Self-checking bench for pixel_stream_capture on a reduced raster, using a queue-based
// reference model of the captured beats, flags, pixel count and CRC.
module tb_pixel_stream_capture;

  localparam int unsigned H  = 24;
  localparam int unsigned V  = 5;
  localparam int unsigned D  = 8;
  localparam int unsigned HT = 28;
  localparam int unsigned VT = 7;

  logic        clk_in = 1'b0;
  logic        rst_in, de_in, arm_in, m_ready_in;
  logic [9:0]  sx_in, sy_in;
  logic [7:0]  r_in, g_in, b_in;
  logic [11:0] m_data_out;
  logic        m_sof_out, m_eol_out, m_valid_out, busy_out, done_out, overflow_out, seq_err_out;
  logic [18:0] pix_count_out;
  logic [15:0] crc_out;

  pixel_stream_capture #(
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sx_in         (sx_in),
    .sy_in         (sy_in),
    .de_in         (de_in),
    .r_in          (r_in),
    .g_in          (g_in),
    .b_in          (b_in),
    .arm_in        (arm_in),
    .m_data_out    (m_data_out),
    .m_sof_out     (m_sof_out),
    .m_eol_out     (m_eol_out),
    .m_valid_out   (m_valid_out),
    .m_ready_in    (m_ready_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .overflow_out  (overflow_out),
    .seq_err_out   (seq_err_out),
    .pix_count_out (pix_count_out),
    .crc_out       (crc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [11:0] data;
  } beat_t;

  beat_t       expq[$];
  int          checks, errors;
  int          m_st;  // 0 idle, 1 armed, 2 capturing, 3 draining
  int          ex, ey, cnt, dut_beats, dut_dones;
  logic        m_ovf, m_seq;
  logic [15:0] m_crc;

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = (r << 1) ^ ((r[15] ^ w[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    m_st  = 0;
    ex    = 0;
    ey    = 0;
    cnt   = 0;
    m_ovf = 1'b0;
    m_seq = 1'b0;
    m_crc = 16'h0000;
  endtask

  // One clock: drive, check outputs mid-cycle against the model, advance the model for the edge
  task automatic cycle(input logic rst, input logic arm, input logic de, input int x, input int y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic rdy);
    int          sz0;
    logic        pop, done_exp;
    beat_t       e;
    logic [11:0] d;
    rst_in = rst; arm_in = arm; de_in = de; sx_in = 10'(x); sy_in = 10'(y);
    r_in = r; g_in = g; b_in = b; m_ready_in = rdy;
    #4;
    sz0      = expq.size();
    done_exp = (m_st == 3) && (sz0 == 0);
    chk("m_valid", m_valid_out, sz0 != 0);
    chk("busy", busy_out, m_st != 0);
    chk("done", done_out, done_exp);
    chk("overflow", overflow_out, m_ovf);
    chk("seq_err", seq_err_out, m_seq);
    chk("pix_count", pix_count_out, cnt);
`ifdef CAPTURE_CRC_EN
    chk("crc", crc_out, m_crc);
`else
    chk("crc_off", crc_out, 0);
`endif
    if (m_valid_out && m_ready_in) dut_beats++;
    if (done_out) dut_dones++;
    pop = (sz0 != 0) && rdy;
    if (pop) begin
      e = expq.pop_front();
      chk("beat", {m_sof_out, m_eol_out, m_data_out}, e);
    end
    d = {r[7:4], g[7:4], b[7:4]};
    if (rst) model_reset();
    else begin
      case (m_st)
        0: if (arm) begin
          m_st = 1; m_ovf = 1'b0; m_seq = 1'b0; cnt = 0; m_crc = 16'hFFFF;
        end
        1, 2: if (de && (m_st == 2 || (x == 0 && y == 0))) begin
          if (m_st == 2 && (x != ex || y != ey)) m_seq = 1'b1;
          ex = (x == H - 1) ? 0 : x + 1;
          ey = (x == H - 1) ? y + 1 : y;
          if (sz0 < D || pop) begin
            e.sof  = (m_st == 1);
            e.eol  = (x == H - 1);
            e.data = d;
            expq.push_back(e);
            cnt++;
            m_crc = crc_ref(m_crc, {4'h0, d});
          end else m_ovf = 1'b1;
          m_st = (x == H - 1 && y == V - 1) ? 3 : 2;
        end
        default: if (done_exp) m_st = 0;
      endcase
    end
    @(posedge clk_in);
    #1;
  endtask

  // cmode: 0 random, 1 F0 grey, 2 constant ABC; rmode: 0 ready, 1 stalled on line 0, 2 random, 3 off
  task automatic frame(input int y0, input int nmax, input int cmode, input int rmode,
                       input bit skip);
    int         n;
    logic       de, rdy, arm;
    logic [7:0] r, g, b;
    n = 0;
    for (int y = y0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        if (nmax > 0 && n >= nmax) return;
        de = (x < H) && (y < V) && !(skip && y == 0 && x == 6);
        case (cmode)
          1: begin r = 8'hF0; g = 8'hF0; b = 8'hF0; end
          2: begin
            r = {4'hA, 4'($urandom)}; g = {4'hB, 4'($urandom)}; b = {4'hC, 4'($urandom)};
          end
          default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
        endcase
        case (rmode)
          0: rdy = 1'b1;
          1: rdy = (y != 0);
          2: rdy = ($urandom_range(3) != 0);
          default: rdy = 1'b0;
        endcase
        arm = (rmode == 2) && (y < V - 1) && ($urandom_range(7) == 0);
        cycle(1'b0, arm, de, x, y, r, g, b, rdy);
        if (de) n++;
      end
    end
  endtask

  task automatic arm_now();
    dut_beats = 0;
    dut_dones = 0;
    cycle(1'b0, 1'b1, 1'b0, 0, V, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && busy_out; i++) cycle(1'b0, 1'b0, 1'b0, 0, V, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("drain_idle", busy_out, 0);
  endtask

  logic [15:0] ref_crc;

  initial begin
    checks = 0; errors = 0; dut_beats = 0; dut_dones = 0;
    rst_in = 1'b1; arm_in = 1'b0; de_in = 1'b0; sx_in = '0; sy_in = '0;
    r_in = '0; g_in = '0; b_in = '0; m_ready_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", m_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_pix_count", pix_count_out, 0);
    chk("rst_crc", crc_out, 0);

    // Grey frame, always ready
    arm_now();
    frame(0, 0, 1, 0, 1'b0);
    drain();
    chk("grey_beats", dut_beats, H * V);
    chk("grey_dones", dut_dones, 1);
    chk("grey_overflow", overflow_out, 0);
    chk("grey_seq_err", seq_err_out, 0);

    // Sink stalled for the whole first line
    arm_now();
    frame(0, 0, 0, 1, 1'b0);
    drain();
    chk("stall_overflow", overflow_out, 1);
    chk("stall_beats", dut_beats, H * V - (H - D));

    // Armed mid-frame: nothing until the next frame start
    arm_now();
    frame(2, 0, 0, 0, 1'b0);
    chk("midarm_no_beats", dut_beats, 0);
    frame(0, 0, 0, 0, 1'b0);
    drain();
    chk("midarm_beats", dut_beats, H * V);
    chk("midarm_dones", dut_dones, 1);

    // Pixel (6,0) missing from the stream
    arm_now();
    frame(0, 0, 0, 0, 1'b1);
    drain();
    chk("skip_seq_err", seq_err_out, 1);
    chk("skip_beats", dut_beats, H * V - 1);
    chk("skip_dones", dut_dones, 1);

    // Constant ABC frame for the CRC
    arm_now();
    frame(0, 0, 2, 0, 1'b0);
    drain();
    ref_crc = 16'hFFFF;
    for (int i = 0; i < H * V; i++) ref_crc = crc_ref(ref_crc, 16'h0ABC);
`ifdef CAPTURE_CRC_EN
    chk("abc_crc", crc_out, ref_crc);
`else
    chk("abc_crc_off", crc_out, 0);
`endif
    chk("abc_pix_count", pix_count_out, H * V);

    // Random colours with random back-pressure and stray arm pulses
    for (int k = 0; k < 2; k++) begin
      arm_now();
      frame(0, 0, 0, 2, 1'b0);
      drain();
      chk("rand_dones", dut_dones, 1);
    end

    // Reset with five beats queued
    arm_now();
    frame(0, 5, 0, 3, 1'b0);
    chk("pre_rst_pix_count", pix_count_out, 5);
    cycle(1'b1, 1'b0, 1'b1, 5, 0, 8'h12, 8'h34, 8'h56, 1'b0);
    chk("post_rst_valid", m_valid_out, 0);
    chk("post_rst_busy", busy_out, 0);
    chk("post_rst_pix_count", pix_count_out, 0);
    chk("post_rst_overflow", overflow_out, 0);
    cycle(1'b0, 1'b0, 1'b1, 6, 0, 8'h12, 8'h34, 8'h56, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
